// File: rtl/instr_encoder_loader.sv
// Assembles RV32I instruction words from field bundles and streams them into instruction memory.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for Start_i
// LOAD   | accepting bundles, one write per accepted bundle
// DONE   | session ended by Last_i, outputs hold
// ERR    | DEPTH words written without Last_i, outputs hold
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0040_0000,
    parameter int DEPTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic                  Last_i,
    input  logic [2:0]            Format_i,
    input  logic [4:0]            Rd_i,
    input  logic [4:0]            Rs1_i,
    input  logic [4:0]            Rs2_i,
    input  logic [2:0]            Funct3_i,
    input  logic [6:0]            Funct7_i,
    input  logic [31:0]           Imm_i,
    output logic                  Mem_Write_o,
    output logic [ADDR_WIDTH-1:0] Address_o,
    output logic [31:0]           Write_Data_o,
    output logic [CW-1:0]         Count_o,
    output logic                  Done_o,
    output logic                  Overflow_o,
    output logic                  Imm_Err_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   addr_out_q, addr_out_d;
    logic [31:0]             data_q, data_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    wr_q, wr_d;
    logic                    ovf_q, ovf_d;
    logic                    imm_err_q, imm_err_d;
    logic [31:0]             enc;
    logic                    imm_ok;
    logic                    ready;
    logic                    accept;
    logic                    start_take;
    logic                    last_slot;

    always_comb begin
        enc = '0;
        case (Format_i)
            3'd0:    enc = {Funct7_i, Rs2_i, Rs1_i, Funct3_i, Rd_i, 7'h33};
            3'd1:    enc = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, 7'h13};
            3'd2:    enc = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, 7'h03};
            3'd3:    enc = {Imm_i[11:0], Rs1_i, 3'b000, Rd_i, 7'h67};
            3'd4:    enc = {Imm_i[11:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:0], 7'h23};
            3'd5:    enc = {Imm_i[12], Imm_i[10:5], Rs2_i, Rs1_i, Funct3_i,
                            Imm_i[4:1], Imm_i[11], 7'h63};
            3'd6:    enc = {Imm_i[31:12], Rd_i, 7'h37};
            default: enc = {Imm_i[20], Imm_i[10:1], Imm_i[11], Imm_i[19:12], Rd_i, 7'h6F};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A value fits a signed N-bit field when all bits from N-1 upward agree.
    always_comb begin
        imm_ok = 1'b1;
        case (Format_i)
            3'd1, 3'd2, 3'd3, 3'd4:
                imm_ok = (&Imm_i[31:11]) | ~(|Imm_i[31:11]);
            3'd5:    imm_ok = ((&Imm_i[31:12]) | ~(|Imm_i[31:12])) & ~Imm_i[0];
            3'd6:    imm_ok = (Imm_i[11:0] == 12'h000);
            3'd7:    imm_ok = ((&Imm_i[31:20]) | ~(|Imm_i[31:20])) & ~Imm_i[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign ready      = (state_q == S_LOAD) && (count_q < DEPTH_C);
    assign accept     = ready && Valid_i;
    assign start_take = (state_q != S_LOAD) && Start_i;
    assign last_slot  = (count_q == DEPTH_C - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (accept && Last_i)                    state_d = S_DONE;
                else if (accept && imm_ok && last_slot)  state_d = S_ERR;
            end
            default: if (Start_i) state_d = S_LOAD;
        endcase
    end

    always_comb begin
        Ready_o = ready;
        Done_o  = (state_q == S_DONE) || (state_q == S_ERR);
    end

    always_comb begin
        addr_d     = addr_q;
        addr_out_d = addr_out_q;
        data_d     = data_q;
        count_d    = count_q;
        wr_d       = 1'b0;
        ovf_d      = ovf_q;
        imm_err_d  = imm_err_q;
        if (start_take) begin
            addr_d    = BASE_ADDR;
            count_d   = '0;
            ovf_d     = 1'b0;
            imm_err_d = 1'b0;
        end
        if (accept) begin
            if (imm_ok) begin
                wr_d       = 1'b1;
                addr_out_d = addr_q;
                data_d     = enc;
                addr_d     = addr_q + ADDR_WIDTH'(4);
                count_d    = count_q + CW'(1);
                if (!Last_i && last_slot) ovf_d = 1'b1;
            end else begin
                imm_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= BASE_ADDR;
            addr_out_q <= '0;
            data_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            ovf_q      <= 1'b0;
            imm_err_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_out_q <= addr_out_d;
            data_q     <= data_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            ovf_q      <= ovf_d;
            imm_err_q  <= imm_err_d;
        end
    end

    assign Mem_Write_o  = wr_q;
    assign Address_o    = addr_out_q;
    assign Write_Data_o = data_q;
    assign Count_o      = count_q;
    assign Overflow_o   = ovf_q;
    assign Imm_Err_o    = imm_err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of encoded bundles plus session sequences.
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_i, Valid_i, Last_i;
    logic        Ready_o;
    logic [2:0]  Format_i;
    logic [4:0]  Rd_i, Rs1_i, Rs2_i;
    logic [2:0]  Funct3_i;
    logic [6:0]  Funct7_i;
    logic [31:0] Imm_i;
    logic        Mem_Write_o;
    logic [31:0] Address_o;
    logic [31:0] Write_Data_o;
    logic [6:0]  Count_o;
    logic        Done_o, Overflow_o, Imm_Err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    instr_encoder_loader dut (
        .clk(clk), .reset(reset), .Start_i(Start_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
        .Last_i(Last_i), .Format_i(Format_i), .Rd_i(Rd_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i),
        .Funct3_i(Funct3_i), .Funct7_i(Funct7_i), .Imm_i(Imm_i), .Mem_Write_o(Mem_Write_o),
        .Address_o(Address_o), .Write_Data_o(Write_Data_o), .Count_o(Count_o),
        .Done_o(Done_o), .Overflow_o(Overflow_o), .Imm_Err_o(Imm_Err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fields(input int i);
        Format_i = vecs[i].fmt;
        Rd_i     = vecs[i].rd;
        Rs1_i    = vecs[i].rs1;
        Rs2_i    = vecs[i].rs2;
        Funct3_i = vecs[i].f3;
        Funct7_i = vecs[i].f7;
        Imm_i    = vecs[i].imm;
    endtask

    // One accepted bundle; its write must appear right after the accepting edge.
    task automatic send(input int i, input logic last, input logic [31:0] exp_addr);
        load_fields(i);
        Valid_i = 1'b1;
        Last_i  = last;
        check($sformatf("ready_v%0d", i), Ready_o, 1);
        tick();
        Valid_i = 1'b0;
        Last_i  = 1'b0;
        check($sformatf("wr_v%0d", i), Mem_Write_o, 1);
        check($sformatf("addr_v%0d", i), Address_o, exp_addr);
        check($sformatf("data_v%0d", i), Write_Data_o, vecs[i].exp);
    endtask

    task automatic start();
        Start_i = 1'b1;
        tick();
        Start_i = 1'b0;
    endtask

    initial begin
        //            fmt   rd     rs1    rs2    f3    f7      imm            expected
        vecs[0]  = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0050_0093};
        vecs[1]  = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020_A423};
        vecs[2]  = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3};
        vecs[3]  = '{3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7};
        vecs[4]  = '{3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,         32'h0080_00EF};
        vecs[5]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0020_81B3};
        vecs[6]  = '{3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0,         32'h4073_02B3};
        vecs[7]  = '{3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFF8, 32'hFF81_2203};
        vecs[8]  = '{3'd3, 5'd1, 5'd5, 5'd0, 3'd3, 7'h00, 32'h10,        32'h0102_80E7};
        vecs[9]  = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0000_0163};
        vecs[10] = '{3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,         32'h0010_0013};

        reset = 1'b1; Start_i = 1'b0; Valid_i = 1'b0; Last_i = 1'b0;
        load_fields(0);
        tick(); tick();
        check("rst_ready", Ready_o, 0);
        check("rst_wr", Mem_Write_o, 0);
        check("rst_addr", Address_o, 0);
        check("rst_data", Write_Data_o, 0);
        check("rst_count", 32'(Count_o), 0);
        check("rst_done", Done_o, 0);
        check("rst_ovf", Overflow_o, 0);
        check("rst_imm_err", Imm_Err_o, 0);
        reset = 1'b0;
        Valid_i = 1'b1;
        tick();
        Valid_i = 1'b0;
        check("idle_no_accept", Mem_Write_o, 0);

        // Single-word session
        start();
        check("load_ready", Ready_o, 1);
        check("load_done", Done_o, 0);
        send(0, 1'b1, BASE);
        tick();
        check("s1_done", Done_o, 1);
        check("s1_count", 32'(Count_o), 1);
        check("s1_wr_off", Mem_Write_o, 0);
        check("s1_ready_off", Ready_o, 0);

        // Back-to-back S, B, U, J
        start();
        for (int i = 1; i <= 4; i++) send(i, i == 4, BASE + 32'(4 * (i - 1)));
        check("s2_done", Done_o, 1);
        check("s2_count", 32'(Count_o), 4);

        // Two-word session, restart from DONE, Start ignored while loading
        start();
        send(5, 1'b0, BASE);
        send(6, 1'b1, BASE + 4);
        check("s3_count", 32'(Count_o), 2);
        start();
        check("restart_count", 32'(Count_o), 0);
        check("restart_done", Done_o, 0);
        check("restart_ovf", Overflow_o, 0);
        send(7, 1'b0, BASE);
        Start_i = 1'b1;
        tick();
        Start_i = 1'b0;
        check("start_in_load_count", 32'(Count_o), 1);
        check("start_in_load_ready", Ready_o, 1);
        send(8, 1'b1, BASE + 4);
        check("s4_count", 32'(Count_o), 2);

        // Overflow: DEPTH bundles without Last_i
        start();
        load_fields(0);
        Valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            check($sformatf("ovf_wr_%0d", i), Mem_Write_o, 1);
            check($sformatf("ovf_addr_%0d", i), Address_o, BASE + 32'(4 * i));
        end
        check("ovf_final_addr", Address_o, 32'h0040_00FC);
        check("ovf_ready", Ready_o, 0);
        check("ovf_flag", Overflow_o, 1);
        check("ovf_done", Done_o, 1);
        check("ovf_count", 32'(Count_o), 64);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ovf_no_wr_%0d", i), Mem_Write_o, 0);
        end
        Valid_i = 1'b0;
        start();
        check("ovf_cleared", Overflow_o, 0);
        check("ovf_restart_count", 32'(Count_o), 0);

        // Reset during the third write cycle
        send(5, 1'b0, BASE);
        send(6, 1'b0, BASE + 4);
        send(7, 1'b0, BASE + 8);
        reset = 1'b1;
        load_fields(8);
        Valid_i = 1'b1;
        tick();
        check("mid_rst_wr", Mem_Write_o, 0);
        check("mid_rst_addr", Address_o, 0);
        check("mid_rst_data", Write_Data_o, 0);
        check("mid_rst_count", 32'(Count_o), 0);
        check("mid_rst_done", Done_o, 0);
        check("mid_rst_ready", Ready_o, 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("post_rst_no_wr_%0d", i), Mem_Write_o, 0);
            check($sformatf("post_rst_ready_%0d", i), Ready_o, 0);
        end
        Valid_i = 1'b0;
        start();
        send(0, 1'b1, BASE);

        // Out-of-range B immediate followed by a valid last bundle
        start();
`ifdef IMM_RANGE_CHECK_EN
        load_fields(9);
        Valid_i = 1'b1;
        tick();
        Valid_i = 1'b0;
        check("imm_bad_no_wr", Mem_Write_o, 0);
        check("imm_err_set", Imm_Err_o, 1);
        check("imm_bad_count", 32'(Count_o), 0);
        send(10, 1'b1, BASE);
        tick();
        check("imm_done", Done_o, 1);
        check("imm_count", 32'(Count_o), 1);
        check("imm_err_sticky", Imm_Err_o, 1);
        start();
        check("imm_err_cleared", Imm_Err_o, 0);
`else
        send(9, 1'b0, BASE);
        send(10, 1'b1, BASE + 4);
        tick();
        check("imm_done", Done_o, 1);
        check("imm_count", 32'(Count_o), 2);
        check("imm_err_tied", Imm_Err_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
